// File: rtl/vie_mdu_pkg.sv
// Shared definitions for the vie_mdu multiply/divide unit.
//   - vie_mdu_op_e    : request opcode encoding
//   - vie_mdu_state_e : control FSM states
//   - vie_mdu_cond_neg: conditional two's-complement negation. It works on a wide
//                       container so any WIDTH up to VieMduMaxWidth can use it; the
//                       low bits of a negation depend only on the low bits of the input.
package vie_mdu_pkg;

  typedef enum logic [1:0] {
    VIE_MDU_MULT  = 2'b00,
    VIE_MDU_MULTU = 2'b01,
    VIE_MDU_DIV   = 2'b10,
    VIE_MDU_DIVU  = 2'b11
  } vie_mdu_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } vie_mdu_state_e;

  localparam int unsigned VieMduMaxWidth = 256;

  function automatic logic [VieMduMaxWidth-1:0] vie_mdu_cond_neg(
    input logic [VieMduMaxWidth-1:0] i_val,
    input logic                      i_neg
  );
    return i_neg ? -i_val : i_val;
  endfunction

endpackage

// File: rtl/vie_mdu_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes.
//   clock, reset   : clock, synchronous active-high reset
//   i_start        : load operands; the first quotient bit is produced on this edge
//   i_kill         : abandon the division in progress
//   i_dividend     : unsigned dividend
//   i_divisor      : unsigned divisor (non-zero)
//   o_done         : the final iteration completes on the coming clock edge
//   o_quotient     : quotient, valid the cycle after o_done
//   o_remainder    : remainder, valid the cycle after o_done
module vie_mdu_div_core
  import vie_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_kill,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_rem, r_quo, r_dvs;
  logic [CntW-1:0]    r_cnt;
  logic               r_active;
  logic [2*WIDTH-1:0] w_first, w_step;

  // One restoring step: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits. Returns {remainder, quotient/dividend shift reg}.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] i_rem,
    input logic [WIDTH-1:0] i_quo,
    input logic [WIDTH-1:0] i_dvs
  );
    logic [WIDTH:0] w_shift, w_trial;
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_dvs};
    if (w_trial[WIDTH]) begin
      return {w_shift[WIDTH-1:0], i_quo[WIDTH-2:0], 1'b0};
    end
    return {w_trial[WIDTH-1:0], i_quo[WIDTH-2:0], 1'b1};
  endfunction

  assign w_first = div_step('0, i_dividend, i_divisor);
  assign w_step  = div_step(r_rem, r_quo, r_dvs);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_kill) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      {r_rem, r_quo} <= w_first;
      r_dvs          <= i_divisor;
      r_cnt          <= CntW'(WIDTH - 1);
      r_active       <= 1'b1;
    end else if (r_active) begin
      {r_rem, r_quo} <= w_step;
      r_cnt          <= r_cnt - CntW'(1);
      if (r_cnt == CntW'(1)) r_active <= 1'b0;
    end
  end

  assign o_done      = r_active && (r_cnt == CntW'(1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/vie_mdu.sv
// Multi-cycle multiply/divide unit for the execute stage; one operation in flight.
//   clock, reset          : clock, synchronous active-high reset (also clears datapath)
//   flush                 : drop any in-flight or pending result
//   req_valid/req_ready   : request handshake; req_op selects mult/multu/div/divu
//   req_a, req_b          : multiplicand/dividend, multiplier/divisor
//   resp_valid/resp_ready : response handshake
//   resp_hi, resp_lo      : product high/low halves, or remainder/quotient
//   resp_dbz              : divide-by-zero flag, qualified by resp_valid
//   busy                  : unit is not idle
module vie_mdu
  import vie_mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic             resp_dbz,
  output logic             busy
);

  localparam int unsigned McW     = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam int unsigned MulLoad = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

  vie_mdu_state_e     r_state, w_state_d;
  logic [McW-1:0]     r_mul_cnt;
  logic               r_neg_q, r_neg_r, r_dbz;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               w_accept, w_req_mul, w_req_signed, w_b_zero, w_div_start, w_div_done;
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_quo_fix, w_rem_fix;

  assign req_ready    = (r_state == StIdle) && !flush;
  assign w_accept     = req_valid && req_ready;
  assign w_req_mul    = (req_op == VIE_MDU_MULT) || (req_op == VIE_MDU_MULTU);
  assign w_req_signed = (req_op == VIE_MDU_MULT) || (req_op == VIE_MDU_DIV);
  assign w_b_zero     = (req_b == '0);

  // Sign- or zero-extend to 2*WIDTH so one unsigned multiply yields the full product.
  assign w_mul_a = {{WIDTH{w_req_signed & req_a[WIDTH-1]}}, req_a};
  assign w_mul_b = {{WIDTH{w_req_signed & req_b[WIDTH-1]}}, req_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // |min| is 2^(WIDTH-1) as an unsigned value, so min / -1 falls out naturally.
  assign w_a_mag = WIDTH'(vie_mdu_cond_neg(VieMduMaxWidth'(req_a), w_req_signed & req_a[WIDTH-1]));
  assign w_b_mag = WIDTH'(vie_mdu_cond_neg(VieMduMaxWidth'(req_b), w_req_signed & req_b[WIDTH-1]));
  assign w_div_start = w_accept && !w_req_mul && !w_b_zero;

  vie_mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_kill     (flush),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_done     (w_div_done),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );

  assign w_quo_fix = WIDTH'(vie_mdu_cond_neg(VieMduMaxWidth'(w_quo), r_neg_q));
  assign w_rem_fix = WIDTH'(vie_mdu_cond_neg(VieMduMaxWidth'(w_rem), r_neg_r));

  always_ff @(posedge clock) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_req_mul)     w_state_d = (MUL_STAGES == 1) ? StDone : StMul;
          else if (w_b_zero) w_state_d = StDone;
          else               w_state_d = StDiv;
        end
      end
      StMul:   if (r_mul_cnt == '0) w_state_d = StDone;
      StDiv:   if (w_div_done) w_state_d = StFix;
      StFix:   w_state_d = StDone;
      StDone:  if (resp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (flush) w_state_d = StIdle;
  end

  // The product is formed at accept and simply held while MUL counts out its latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mul_cnt <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mul_cnt <= McW'(MulLoad);
        r_neg_q   <= w_req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
        r_neg_r   <= w_req_signed & req_a[WIDTH-1];
        r_dbz     <= !w_req_mul && w_b_zero;
        if (w_req_mul) begin
          {r_hi, r_lo} <= w_prod;
        end else if (w_b_zero) begin
          r_hi <= req_a;
          r_lo <= '1;
        end
      end else if ((r_state == StMul) && (r_mul_cnt != '0)) begin
        r_mul_cnt <= r_mul_cnt - McW'(1);
      end
      if (r_state == StFix) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end
    end
  end

  assign resp_valid = (r_state == StDone);
  assign resp_hi    = r_hi;
  assign resp_lo    = r_lo;
  assign resp_dbz   = r_dbz;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_vie_mdu.sv
module tb_vie_mdu;
  import vie_mdu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, req_valid, resp_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  bit          sel;  // 0: WIDTH=32/MUL_STAGES=2 instance, 1: WIDTH=16/MUL_STAGES=1

  logic        rdy32, val32, dbz32, busy32;
  logic [31:0] hi32, lo32;
  logic        rdy16, val16, dbz16, busy16;
  logic [15:0] hi16, lo16;
  logic        rv32, rv16;

  assign rv32 = req_valid & ~sel;
  assign rv16 = req_valid & sel;

  vie_mdu #(.WIDTH(32), .MUL_STAGES(2)) u_dut32 (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(rv32), .req_ready(rdy32), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(val32), .resp_ready(resp_ready), .resp_hi(hi32), .resp_lo(lo32),
    .resp_dbz(dbz32), .busy(busy32)
  );

  vie_mdu #(.WIDTH(16), .MUL_STAGES(1)) u_dut16 (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(rv16), .req_ready(rdy16), .req_op(req_op), .req_a(req_a[15:0]),
    .req_b(req_b[15:0]), .resp_valid(val16), .resp_ready(resp_ready), .resp_hi(hi16),
    .resp_lo(lo16), .resp_dbz(dbz16), .busy(busy16)
  );

  logic        m_ready, m_valid, m_dbz, m_busy;
  logic [31:0] m_hi, m_lo;
  assign m_ready = sel ? rdy16 : rdy32;
  assign m_valid = sel ? val16 : val32;
  assign m_dbz   = sel ? dbz16 : dbz32;
  assign m_busy  = sel ? busy16 : busy32;
  assign m_hi    = sel ? {16'd0, hi16} : hi32;
  assign m_lo    = sel ? {16'd0, lo16} : lo32;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic (SV / and % truncate toward zero).
  function automatic void model(input bit s16, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dbz, output int lat);
    int w;
    longint unsigned mask, ua, ub, p;
    longint sa, sb;
    bit sgn;
    w    = s16 ? 16 : 32;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sgn  = (op == VIE_MDU_MULT) || (op == VIE_MDU_DIV);
    sa   = (sgn && ua > (mask >> 1)) ? longint'(ua) - longint'(mask) - 64'sd1 : longint'(ua);
    sb   = (sgn && ub > (mask >> 1)) ? longint'(ub) - longint'(mask) - 64'sd1 : longint'(ub);
    dbz  = 1'b0;
    if ((op == VIE_MDU_MULT) || (op == VIE_MDU_MULTU)) begin
      p   = sgn ? longint'(sa * sb) : ua * ub;
      lo  = 32'(p & mask);
      hi  = 32'((p >> w) & mask);
      lat = s16 ? 1 : 2;
    end else if (ub == 0) begin
      hi  = 32'(ua);
      lo  = 32'(mask);
      dbz = 1'b1;
      lat = 1;
    end else begin
      if (sgn) begin
        lo = 32'(longint'(sa / sb) & mask);
        hi = 32'(longint'(sa % sb) & mask);
      end else begin
        lo = 32'(ua / ub);
        hi = 32'(ua % ub);
      end
      lat = w + 1;
    end
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    check("req_ready_before_issue", {31'd0, m_ready}, 32'd1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // lat = number of clock edges from the accept edge until resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clock);
      lat++;
      if (m_valid) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat);
  endtask

  task automatic run_op(input string name, input bit s16, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edbz, input int elat);
    int lat;
    sel = s16;
    issue(op, a, b);
    wait_resp(lat);
    check({name, "_hi"}, m_hi, ehi);
    check({name, "_lo"}, m_lo, elo);
    check({name, "_dbz"}, {31'd0, m_dbz}, {31'd0, edbz});
    check({name, "_latency"}, lat, elat);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          s16;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, bad;
    logic [31:0] ehi, elo, hold_hi, hold_lo;
    logic        edbz, hold_dbz;
    logic [1:0]  op;
    bit          s16;
    logic [31:0] a, b;

    vecs[0]  = '{"multu_max", 0, VIE_MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2};
    vecs[1]  = '{"mult_m3x5", 0, VIE_MDU_MULT, 32'hFFFF_FFFD, 32'd5,
                 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 2};
    vecs[2]  = '{"div_m7_2", 0, VIE_MDU_DIV, 32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[3]  = '{"divu_100_7", 0, VIE_MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
    vecs[4]  = '{"divu_by0", 0, VIE_MDU_DIVU, 32'd100, 32'd0,
                 32'd100, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[5]  = '{"div_ovf", 0, VIE_MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'd0, 32'h8000_0000, 1'b0, 33};
    vecs[6]  = '{"div_by0_signed", 0, VIE_MDU_DIV, 32'hFFFF_FFFB, 32'd0,
                 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[7]  = '{"w16_div_min_3", 1, VIE_MDU_DIV, 32'h8000, 32'd3, 32'hFFFE, 32'hD556, 1'b0, 17};
    vecs[8]  = '{"w16_mult_min_min", 1, VIE_MDU_MULT, 32'h8000, 32'h8000,
                 32'h4000, 32'h0000, 1'b0, 1};
    vecs[9]  = '{"w16_divu_max_1", 1, VIE_MDU_DIVU, 32'hFFFF, 32'd1, 32'd0, 32'hFFFF, 1'b0, 17};
    vecs[10] = '{"w16_div_7_m2", 1, VIE_MDU_DIV, 32'd7, 32'hFFFE, 32'd1, 32'hFFFD, 1'b0, 17};
    vecs[11] = '{"w16_multu_max", 1, VIE_MDU_MULTU, 32'hFFFF, 32'hFFFF,
                 32'hFFFE, 32'h0001, 1'b0, 1};

    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 2'b00; req_a = '0; req_b = '0; sel = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_resp_valid32", {31'd0, val32}, 32'd0);
    check("rst_busy32", {31'd0, busy32}, 32'd0);
    check("rst_hi32", hi32, 32'd0);
    check("rst_lo32", lo32, 32'd0);
    check("rst_dbz32", {31'd0, dbz32}, 32'd0);
    check("rst_resp_valid16", {31'd0, val16}, 32'd0);
    check("rst_hi16", {16'd0, hi16}, 32'd0);
    check("rst_lo16", {16'd0, lo16}, 32'd0);
    check("rst_busy16", {31'd0, busy16}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_req_ready32", {31'd0, rdy32}, 32'd1);
    check("rst_req_ready16", {31'd0, rdy16}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].s16, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
    end

    // Backpressure: DONE held for 5 cycles with a competing request present.
    sel = 1'b0;
    issue(VIE_MDU_DIVU, 32'd100, 32'd7);
    wait_resp(lat);
    hold_hi = m_hi; hold_lo = m_lo; hold_dbz = m_dbz;
    check("bp_first_lo", hold_lo, 32'd14);
    bad = 0;
    req_valid = 1'b1; req_op = VIE_MDU_MULTU; req_a = 32'd9; req_b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (!m_valid || m_ready || m_hi !== hold_hi || m_lo !== hold_lo || m_dbz !== hold_dbz)
        bad++;
    end
    check("bp_hold_cycles_bad", bad, 32'd0);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("bp_idle_busy", {31'd0, m_busy}, 32'd0);
    check("bp_idle_ready", {31'd0, m_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, m_valid}, 32'd0);

    // Flush 10 cycles into a divide with a request presented in the same cycle.
    issue(VIE_MDU_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clock);
    flush = 1'b1; req_valid = 1'b1; req_op = VIE_MDU_MULTU; req_a = 32'd3; req_b = 32'd4;
    @(posedge clock);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    check("flush_ready_next", {31'd0, m_ready}, 32'd1);
    check("flush_busy_next", {31'd0, m_busy}, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (m_valid || m_busy) bad++;
    end
    check("flush_no_resp", bad, 32'd0);
    run_op("post_flush_multu", 1'b0, VIE_MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 2);

    // Flush beats resp_ready on a pending result.
    issue(VIE_MDU_MULT, 32'd6, 32'd7);
    wait_resp(lat);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0; resp_ready = 1'b0;
    @(negedge clock);
    check("flush_done_valid", {31'd0, m_valid}, 32'd0);

    // Randomised mix on both instances.
    for (int i = 0; i < 150; i++) begin
      s16 = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = s16 ? 32'h0000_8000 : 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (s16) begin
        a = a & 32'h0000_FFFF;
        b = b & 32'h0000_FFFF;
      end
      model(s16, op, a, b, ehi, elo, edbz, lat);
      run_op($sformatf("rand%0d", i), s16, op, a, b, ehi, elo, edbz, lat);
    end

    // Reset mid-divide clears state and response registers.
    sel = 1'b0;
    run_op("pre_reset_mult", 1'b0, VIE_MDU_MULT, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 2);
    issue(VIE_MDU_DIVU, 32'd500, 32'd3);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_busy", {31'd0, m_busy}, 32'd0);
    check("midrst_lo", m_lo, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (m_valid) bad++;
    end
    check("midrst_no_resp", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vie_mdu.md
Name: vie_mdu

Overview:
Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the fixed 32-bit combinational multiplier and the vendor divider cores with one self-contained block. Uses a valid/ready request/response handshake, supports flush and arbitrary data width, and returns a {hi, lo} pair that the execute stage writes into HI/LO. One operation is in flight at a time.

Parameters:
WIDTH, 32, operand width in bits; >= 8, even.
MUL_STAGES, 2, cycles from accept to multiply result; >= 1.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; clock clock
flush  in  1  cancel in-flight op (exception/redirect)
req_valid  in  1  request present
req_ready  out  1  unit can accept
req_op  in  2  00 mult, 01 multu, 10 div, 11 divu
req_a  in  WIDTH  multiplicand / dividend
req_b  in  WIDTH  multiplier / divisor
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_hi  out  WIDTH  product high half / remainder
resp_lo  out  WIDTH  product low half / quotient
resp_dbz  out  1  divide-by-zero flag, qualified by resp_valid
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE.
- req_ready = (state==IDLE) && !flush. Accept = req_valid && req_ready. On accept, operands and op are latched.
- Accept in IDLE:
  - mult/multu -> MUL.
  - div/divu with req_b==0 -> DONE.
  - div/divu otherwise -> DIV.
- MUL:
  - Signed or unsigned full product, 2*WIDTH bits.
  - Stays MUL_STAGES-1 cycles, then DONE. resp_valid first high MUL_STAGES cycles after the accept edge.
  - Product may be computed in one cycle and delayed, or pipelined; either is acceptable.
- DIV:
  - Restoring radix-2 division on magnitudes; signed ops take |a| and |b| first.
  - WIDTH iterations, one per cycle, counter of width $clog2(WIDTH+1), then FIX.
- FIX (1 cycle):
  - Quotient negated if signed and sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - Then DONE. Divide latency is WIDTH+1 cycles from the accept edge.
- Zero divisor: result lands in DONE one cycle after accept, with resp_hi = req_a, resp_lo = all ones, resp_dbz = 1. Applies to both signed and unsigned.
- Signed overflow (min / -1): quotient = min, remainder = 0, resp_dbz = 0.
- DONE:
  - resp_valid = 1; resp_hi, resp_lo and resp_dbz are held stable until resp_ready.
  - resp_valid && resp_ready -> IDLE.
  - No new accept is possible in the same cycle; the earliest next accept is the following cycle.
- flush (any state): next state is IDLE, resp_valid drops next cycle, and any in-flight or pending result is discarded. flush wins over resp_ready and req_valid in the same cycle.
- reset at any time behaves like flush and also clears the datapath.
- Reset values: resp_valid 0, resp_hi 0, resp_lo 0, resp_dbz 0, busy 0, state IDLE. req_ready is 1 after reset (when flush is low).
- Product/result widths: lo = bits [WIDTH-1:0], hi = bits [2*WIDTH-1:WIDTH]. No truncation warnings are allowed; use explicit widths.

Decomposition:
- Package vie_mdu_pkg: op encodings (VIE_MDU_MULT/MULTU/DIV/DIVU), state encoding, and a helper function for conditional two's-complement negation.
- Sub-module vie_mdu_div_core: iterative restoring divider.
  - Inputs: start, unsigned dividend/divisor (WIDTH), kill.
  - Outputs: done, quotient, remainder.
- The top level owns the FSM, sign handling, multiplier and response register.

Test Plan:
- WIDTH=32, MUL_STAGES=2: multu 0xFFFFFFFF*0xFFFFFFFF -> resp_hi=0xFFFFFFFE, resp_lo=0x00000001, resp_valid exactly 2 cycles after accept. mult -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, latency 33 cycles. divu 100/7 -> lo=14, hi=2.
- divu 100/0 -> one cycle later resp_hi=100, resp_lo=0xFFFFFFFF, resp_dbz=1. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, resp_dbz=0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> outputs constant and req_ready=0 throughout. resp_ready=1 -> IDLE next cycle.
- flush 10 cycles into a div, with req_valid=1 in the same cycle -> no response, request not accepted, req_ready=1 the next cycle. A following multu 3*4 completes with lo=12.
- WIDTH=16, MUL_STAGES=1: div 0x8000 / 3 -> lo=0xD556, hi=0xFFFE, latency 17. Random signed/unsigned mix checked against a reference model.
